// File: rtl/mmc_boot_sequencer.sv
// mmc_boot_sequencer: supervises the MMC-to-FPGA configuration core.
// Holds the core disabled through a power-up settle window, enables it once
// INIT is released, then watches DONE, core_error, INIT and a watchdog.
// Faults pulse a PROG request and retry a bounded number of times.
// Ports:
//   cclk        configuration clock (sole clock)
//   rst_n       synchronous active-low reset
//   init, done  FPGA pins, asynchronous, 2-flop synchronised here
//   core_error  cclk-synchronous error from the boot core
//   core_dis    1 = core tristated/idle
//   prog_req    active-high request to pulse FPGA PROG_B
//   boot_busy   non-terminal state
//   boot_ok     DONE seen
//   boot_fail   retries exhausted
//   retry_cnt   retries issued since reset (or since last external reconfig)
//   fault_code  last fault: 00 none, 01 core_error, 10 INIT low, 11 timeout
module mmc_boot_sequencer #(
  parameter int unsigned PWRUP_CYCLES   = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned PROG_CYCLES    = 16,
  parameter int unsigned CNT_W          = 21,
  parameter int unsigned RTY_W          = 2
) (
  input  logic             cclk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             done,
  input  logic             core_error,
  output logic             core_dis,
  output logic             prog_req,
  output logic             boot_busy,
  output logic             boot_ok,
  output logic             boot_fail,
  output logic [RTY_W-1:0] retry_cnt,
  output logic [1:0]       fault_code
);

  localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PROG_LAST    = CNT_W'(PROG_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX      = RTY_W'(MAX_RETRIES);

  localparam logic [1:0] FC_CORE_ERR = 2'b01;
  localparam logic [1:0] FC_INIT_LOW = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    ST_PWRUP     = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_BOOT      = 3'd2,
    ST_PROG      = 3'd3,
    ST_OK        = 3'd4,
    ST_FAIL      = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic [1:0]       fault_q, fault_d;
  logic [1:0]       init_sync_q, done_sync_q;
  logic             init_s, done_s;
  logic             core_dis_q, prog_req_q, boot_busy_q, boot_ok_q, boot_fail_q;

  // Two-flop synchronisers for the asynchronous FPGA pins
  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      init_sync_q <= 2'b00;
      done_sync_q <= 2'b00;
    end else begin
      init_sync_q <= {init_sync_q[0], init};
      done_sync_q <= {done_sync_q[0], done};
    end
  end

  assign init_s = init_sync_q[1];
  assign done_s = done_sync_q[1];

  // Saturating increment of the shared counter
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rty_d   = rty_q;
    fault_d = fault_q;
    unique case (state_q)
      ST_PWRUP: begin
        if (cnt_q >= PWRUP_LAST) begin
          state_d = ST_WAIT_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_INIT: begin
        if (init_s) begin
          state_d = ST_BOOT;
          cnt_d   = '0;
        end
      end
      ST_BOOT: begin
        cnt_d = cnt_inc;
        // DONE has priority over every fault source seen in the same cycle
        if (done_s) begin
          state_d = ST_OK;
        end else if (core_error || !init_s || (cnt_q >= TIMEOUT_LAST)) begin
          if (core_error)   fault_d = FC_CORE_ERR;
          else if (!init_s) fault_d = FC_INIT_LOW;
          else              fault_d = FC_TIMEOUT;
          if (rty_q < RTY_MAX) begin
            rty_d   = rty_q + RTY_W'(1);
            state_d = ST_PROG;
            cnt_d   = '0;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_PROG: begin
        // Fixed-width pulse; INIT is deliberately ignored here
        if (cnt_q >= PROG_LAST) begin
          state_d = ST_WAIT_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_OK: begin
        // DONE dropping means an external reconfiguration started
        if (!done_s) begin
          state_d = ST_WAIT_INIT;
          rty_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_PWRUP;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and outputs; outputs decode the next state
  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      state_q     <= ST_PWRUP;
      cnt_q       <= '0;
      rty_q       <= '0;
      fault_q     <= 2'b00;
      core_dis_q  <= 1'b1;
      prog_req_q  <= 1'b0;
      boot_busy_q <= 1'b1;
      boot_ok_q   <= 1'b0;
      boot_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rty_q       <= rty_d;
      fault_q     <= fault_d;
      core_dis_q  <= (state_d != ST_BOOT);
      prog_req_q  <= (state_d == ST_PROG);
      boot_busy_q <= (state_d != ST_OK) && (state_d != ST_FAIL);
      boot_ok_q   <= (state_d == ST_OK);
      boot_fail_q <= (state_d == ST_FAIL);
    end
  end

  assign core_dis   = core_dis_q;
  assign prog_req   = prog_req_q;
  assign boot_busy  = boot_busy_q;
  assign boot_ok    = boot_ok_q;
  assign boot_fail  = boot_fail_q;
  assign retry_cnt  = rty_q;
  assign fault_code = fault_q;

endmodule

// File: tb/tb_mmc_boot_sequencer.sv
// Directed bench for mmc_boot_sequencer with short windows
// (PWRUP=8, TIMEOUT=32, PROG=16, MAX_RETRIES=3).
module tb_mmc_boot_sequencer;

  logic       cclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init = 1'b0;
  logic       done = 1'b0;
  logic       core_error = 1'b0;
  logic       core_dis, prog_req, boot_busy, boot_ok, boot_fail;
  logic [1:0] retry_cnt, fault_code;

  int n_total = 0;
  int n_pass  = 0;

  mmc_boot_sequencer #(
    .PWRUP_CYCLES  (8),
    .TIMEOUT_CYCLES(32),
    .MAX_RETRIES   (3),
    .PROG_CYCLES   (16),
    .CNT_W         (21),
    .RTY_W         (2)
  ) dut (
    .cclk      (cclk),
    .rst_n     (rst_n),
    .init      (init),
    .done      (done),
    .core_error(core_error),
    .core_dis  (core_dis),
    .prog_req  (prog_req),
    .boot_busy (boot_busy),
    .boot_ok   (boot_ok),
    .boot_fail (boot_fail),
    .retry_cnt (retry_cnt),
    .fault_code(fault_code)
  );

  always #5 cclk = ~cclk;

  // {n edges, rst_n, init, done, core_error, expected outputs after n edges}
  typedef struct {
    int         n;
    logic       rst_n;
    logic       init;
    logic       done;
    logic       err;
    logic [8:0] exp;
  } vec_t;

  function automatic logic [8:0] ex(input logic dis, input logic pr, input logic bz,
                                    input logic ok, input logic fl,
                                    input logic [1:0] rc, input logic [1:0] fc);
    return {dis, pr, bz, ok, fl, rc, fc};
  endfunction

  function automatic vec_t mk(input int n, input logic r, input logic i, input logic d,
                              input logic e, input logic [8:0] x);
    vec_t v;
    v.n = n; v.rst_n = r; v.init = i; v.done = d; v.err = e; v.exp = x;
    return v;
  endfunction

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  function automatic logic [8:0] obs();
    return {core_dis, prog_req, boot_busy, boot_ok, boot_fail, retry_cnt, fault_code};
  endfunction

  vec_t tbl[21];
  int   n;

  initial begin
    // Reset/power-up, done+error collision, fault retry, OK->reconfig, INIT-low, reset in PROG
    tbl[0]  = mk(1,  0, 1, 0, 0, ex(1, 0, 1, 0, 0, 2'd0, 2'b00)); // reset -> PWRUP
    tbl[1]  = mk(8,  1, 1, 0, 0, ex(1, 0, 1, 0, 0, 2'd0, 2'b00)); // end of settle -> WAIT_INIT
    tbl[2]  = mk(1,  1, 1, 0, 0, ex(0, 0, 1, 0, 0, 2'd0, 2'b00)); // BOOT, core enabled
    tbl[3]  = mk(2,  1, 1, 1, 0, ex(0, 0, 1, 0, 0, 2'd0, 2'b00)); // done still in synchroniser
    tbl[4]  = mk(1,  1, 1, 1, 1, ex(1, 0, 0, 1, 0, 2'd0, 2'b00)); // done beats core_error
    tbl[5]  = mk(3,  1, 1, 1, 0, ex(1, 0, 0, 1, 0, 2'd0, 2'b00)); // OK holds
    tbl[6]  = mk(2,  1, 1, 0, 0, ex(1, 0, 0, 1, 0, 2'd0, 2'b00)); // done drop in synchroniser
    tbl[7]  = mk(1,  1, 1, 0, 0, ex(1, 0, 1, 0, 0, 2'd0, 2'b00)); // -> WAIT_INIT
    tbl[8]  = mk(1,  1, 1, 0, 0, ex(0, 0, 1, 0, 0, 2'd0, 2'b00)); // -> BOOT
    tbl[9]  = mk(1,  1, 1, 0, 1, ex(1, 1, 1, 0, 0, 2'd1, 2'b01)); // core_error -> PROG
    tbl[10] = mk(15, 1, 1, 0, 0, ex(1, 1, 1, 0, 0, 2'd1, 2'b01)); // PROG edge 16 still high
    tbl[11] = mk(1,  1, 1, 0, 0, ex(1, 0, 1, 0, 0, 2'd1, 2'b01)); // -> WAIT_INIT
    tbl[12] = mk(1,  1, 1, 0, 0, ex(0, 0, 1, 0, 0, 2'd1, 2'b01)); // -> BOOT
    tbl[13] = mk(2,  1, 1, 1, 0, ex(0, 0, 1, 0, 0, 2'd1, 2'b01));
    tbl[14] = mk(1,  1, 1, 1, 0, ex(1, 0, 0, 1, 0, 2'd1, 2'b01)); // OK, fault kept
    tbl[15] = mk(2,  1, 1, 0, 0, ex(1, 0, 0, 1, 0, 2'd1, 2'b01));
    tbl[16] = mk(1,  1, 1, 0, 0, ex(1, 0, 1, 0, 0, 2'd0, 2'b01)); // reconfig clears retries
    tbl[17] = mk(1,  1, 1, 0, 0, ex(0, 0, 1, 0, 0, 2'd0, 2'b01)); // -> BOOT
    tbl[18] = mk(2,  1, 0, 0, 0, ex(0, 0, 1, 0, 0, 2'd0, 2'b01)); // INIT low in synchroniser
    tbl[19] = mk(1,  1, 0, 0, 0, ex(1, 1, 1, 0, 0, 2'd1, 2'b10)); // INIT low fault -> PROG
    tbl[20] = mk(1,  0, 0, 0, 0, ex(1, 0, 1, 0, 0, 2'd0, 2'b00)); // reset inside PROG

    for (int i = 0; i < 21; i++) begin
      rst_n      = tbl[i].rst_n;
      init       = tbl[i].init;
      done       = tbl[i].done;
      core_error = tbl[i].err;
      for (int k = 0; k < tbl[i].n; k++) step();
      chk($sformatf("vec%0d", i), int'(obs()), int'(tbl[i].exp));
    end

    // Repeated timeouts until retries are exhausted
    rst_n = 1'b0; init = 1'b1; done = 1'b0; core_error = 1'b0;
    step();
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (core_dis && n < 60) begin step(); n++; end
      chk($sformatf("try%0d_boot_entered", t), int'(core_dis), 0);
      n = 0;
      do begin step(); n++; end while (!prog_req && !boot_fail && n < 200);
      chk($sformatf("try%0d_boot_cycles", t), n, 32);
      chk($sformatf("try%0d_fault", t), int'(fault_code), 3);
      if (t < 3) begin
        chk($sformatf("try%0d_retry_cnt", t), int'(retry_cnt), t + 1);
        n = 0;
        while (prog_req && n < 100) begin n++; step(); end
        chk($sformatf("try%0d_prog_width", t), n, 16);
      end else begin
        chk("fail_out", int'(obs()), int'(ex(1, 0, 0, 0, 1, 2'd3, 2'b11)));
      end
    end
    repeat (5) step();
    chk("fail_terminal", int'(obs()), int'(ex(1, 0, 0, 0, 1, 2'd3, 2'b11)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
